bcam_ctrl: RTL and testbench
============================

# bcam_ctrl

Request controller for the binary CAM (`bcam`, REG type). It owns the CAM's write and match ports and arbitrates between a lookup requester and an update (insert/delete) requester. It tracks entry occupancy with a bitmap, allocates free entries on insert, and rejects duplicates. It initialises every entry to a reserved null pattern after reset, so stale or unwritten entries never report a valid hit.

## Interface

Parameters:
- `CAMD`, 16: CAM depth; `ADDRW = $clog2(CAMD)`.
- `CAMW`, 8: pattern width.
- `MLAT`, 1: CAM match latency in cycles, from `camMPatt` driven to `camMatch`/`camMAddr` valid (≥1).
- `NULLP`, all ones (`{CAMW{1'b1}}`): reserved pattern that marks an empty entry.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `lkValid` in 1: lookup request.
- `lkPatt` in CAMW: lookup pattern.
- `lkReady` out 1: lookup accepted this cycle when high with `lkValid`.
- `lkRspVld` out 1: one-cycle lookup response pulse.
- `lkHit` out 1: lookup hit.
- `lkAddr` out ADDRW: hit address; 0 on miss.
- `upValid` in 1: update request.
- `upOp` in 1: 0 = insert `upPatt`; 1 = delete entry `upAddr`.
- `upPatt` in CAMW: insert pattern.
- `upAddr` in ADDRW: delete address.
- `upReady` out 1: update accepted this cycle when high with `upValid`.
- `upRspVld` out 1: one-cycle update response pulse.
- `upRspAddr` out ADDRW: entry written, found, or deleted.
- `upRspDup` out 1: insert found the pattern already present.
- `upRspErr` out 2: 0 ok, 1 full, 2 null pattern, 3 delete of empty entry.
- `busy` out 1: init sweep in progress.
- `count` out ADDRW+1: number of occupied entries.
- `camWEnb`, `camWAddr`, `camWPatt`, `camMPatt` out: drive the CAM.
- `camMatch`, `camMAddr` in: CAM match results.

## Operation

FSM states: INIT, IDLE, LOOK, WAIT, DECIDE, WRITE, RESP.

- **INIT**
  - Entered on reset.
  - Writes `NULLP` to addresses 0..CAMD-1, one per cycle.
  - `busy`=1; both ready outputs 0.
  - Goes to IDLE after address CAMD-1 is written.
- **IDLE**
  - Ready outputs are combinational from the valid inputs. At most one ready is high per cycle.
  - If only one valid is high, that port gets ready.
  - If both are high, the port not granted last gets ready (round-robin flag; lookup wins first after reset).
  - On acceptance the request fields are registered.
- **Lookup**
  - LOOK drives `camMPatt` = pattern.
  - WAIT holds `camMPatt` for the remaining MLAT-1 cycles.
  - DECIDE samples the CAM: hit = `camMatch` & occ[`camMAddr`] & (pattern ≠ `NULLP`).
  - RESP pulses `lkRspVld` with `lkHit`/`lkAddr`.
- **Insert**
  - If `upPatt` == `NULLP`: respond immediately (RESP) with err=2. No CAM access.
  - Otherwise perform the lookup sequence, then at DECIDE:
    - Hit: respond with dup=1, the found address, err=0. No write.
    - Miss and a free entry exists: WRITE asserts `camWEnb` at the lowest-index free address, sets the occ bit, and increments `count`. Then RESP with that address, err=0.
    - Miss and `count`==CAMD: RESP with err=1, addr 0.
- **Delete**
  - occ[`upAddr`]=1: WRITE writes `NULLP` at `upAddr`, clears the occ bit, and decrements `count`. Then RESP with err=0 and `upRspAddr`=`upAddr`.
  - Otherwise: RESP with err=3. No write.
- From RESP the FSM returns to IDLE. The block is fully serial: one request in flight.
- `camWEnb` is asserted only in INIT and WRITE. Writes and match drives never occur in the same cycle.

## Timing

- **Reset**
  - All outputs are 0 except `busy`=1; `camWPatt`=`NULLP`.
  - occ bitmap cleared, `count`=0, round-robin flag = lookup.
  - Reset mid-operation aborts the in-flight request with no response and restarts INIT at address 0.
- **Init:** the first cycle after `rst` falls writes address 0. IDLE is reached CAMD cycles later.
- **Lookup or insert accepted at cycle T**
  - `camMPatt` valid from T+1 to T+MLAT.
  - Sampled at T+MLAT+1.
  - Lookup / dup / full response at T+MLAT+2.
  - Insert write at T+MLAT+2, response at T+MLAT+3.
  - With MLAT=1: lookup response at T+3; insert response at T+4.
- **Delete accepted at T:** write at T+1, response at T+2. Err-3 delete responds at T+1.
- **Null-pattern insert:** response at T+1.
- **Next acceptance:** earliest in the cycle after the response pulse.
- A write at cycle W is visible to a match driven at W+1 or later; the FSM guarantees this ordering.
- Response fields are valid only while the response pulse is high; outside that cycle they hold their last value.

## Test plan

- **Init:** deassert `rst`. `busy`=1 for 16 cycles, `camWEnb` walks addresses 0..15 with 0xFF, then ready returns.
- **Insert and lookup:** insert 0x3C → response addr 0, err 0, `count`=1. Lookup 0x3C → `lkHit`=1, `lkAddr`=0 at T+3. Lookup 0x55 → miss.
- **Duplicate, null, and delete:**
  - Insert 0x3C again → dup=1, addr 0, no `camWEnb`.
  - Insert 0xFF → err 2.
  - Delete addr 0 → err 0, `count`=0; then lookup 0x3C → miss.
  - Delete addr 0 again → err 3.
- **Full and reuse:** insert 16 distinct patterns → addresses 0..15. 17th insert → err 1. Delete addr 5, then insert 0x77 → addr 5.
- **Arbitration:** hold `lkValid` and `upValid` high continuously → grants alternate lookup, update, lookup; ready never high on both ports at once.
- **Reset mid-operation:** pulse `rst` at T+1 of a lookup → no `lkRspVld`, INIT restarts at address 0, `count`=0.

Source files
------------

// File: rtl/bcam_ctrl_if.sv
// rtl/bcam_ctrl_if.sv - lookup/update request, response and CAM port bundle for bcam_ctrl
interface bcam_ctrl_if #(
   parameter int CAMD = 16,
   parameter int CAMW = 8
);
   localparam int ADDRW = $clog2(CAMD);

   logic             lkValid;
   logic [CAMW-1:0]  lkPatt;
   logic             lkReady;
   logic             lkRspVld;
   logic             lkHit;
   logic [ADDRW-1:0] lkAddr;

   logic             upValid;
   logic             upOp;
   logic [CAMW-1:0]  upPatt;
   logic [ADDRW-1:0] upAddr;
   logic             upReady;
   logic             upRspVld;
   logic [ADDRW-1:0] upRspAddr;
   logic             upRspDup;
   logic [1:0]       upRspErr;

   logic             busy;
   logic [ADDRW:0]   count;

   logic             camWEnb;
   logic [ADDRW-1:0] camWAddr;
   logic [CAMW-1:0]  camWPatt;
   logic [CAMW-1:0]  camMPatt;
   logic             camMatch;
   logic [ADDRW-1:0] camMAddr;

   modport slave (
      input  lkValid, lkPatt, upValid, upOp, upPatt, upAddr, camMatch, camMAddr,
      output lkReady, lkRspVld, lkHit, lkAddr, upReady, upRspVld, upRspAddr, upRspDup, upRspErr,
             busy, count, camWEnb, camWAddr, camWPatt, camMPatt
   );

   modport master (
      output lkValid, lkPatt, upValid, upOp, upPatt, upAddr, camMatch, camMAddr,
      input  lkReady, lkRspVld, lkHit, lkAddr, upReady, upRspVld, upRspAddr, upRspDup, upRspErr,
             busy, count, camWEnb, camWAddr, camWPatt, camMPatt
   );
endinterface

// File: rtl/bcam_ctrl.sv
// rtl/bcam_ctrl.sv - serial request controller for a binary CAM
// Nulls every entry after reset, arbitrates lookup/update, allocates lowest free entry.
module bcam_ctrl #(
   parameter int             CAMD  = 16,
   parameter int             CAMW  = 8,
   parameter int             MLAT  = 1,
   parameter logic [CAMW-1:0] NULLP = {CAMW{1'b1}}
) (
   input logic        clk,
   input logic        rst,
   bcam_ctrl_if.slave bus
);
   localparam int ADDRW = $clog2(CAMD);
   localparam int LATW  = (MLAT > 1) ? $clog2(MLAT) : 1;

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOOK, S_WAIT, S_DECIDE, S_WRITE, S_RESP} state_e;

   state_e           state_q, state_d;
   logic [ADDRW-1:0] init_addr_q, init_addr_d;
   logic [CAMD-1:0]  occ_q, occ_d;
   logic [ADDRW:0]   count_q, count_d;
   logic             rr_q, rr_d;
   logic             is_lk_q, is_lk_d;
   logic             op_q, op_d;
   logic [CAMW-1:0]  patt_q, patt_d;
   logic [ADDRW-1:0] addr_q, addr_d;
   logic [LATW-1:0]  lat_q, lat_d;
   logic             lk_hit_q, lk_hit_d;
   logic [ADDRW-1:0] lk_addr_q, lk_addr_d;
   logic [ADDRW-1:0] up_addr_q, up_addr_d;
   logic             up_dup_q, up_dup_d;
   logic [1:0]       up_err_q, up_err_d;

   logic             idle, gnt_lk, gnt_up, hit, full;
   logic [ADDRW-1:0] free_addr;

   // rr_q set means lookup won last, so update has priority on the next tie
   assign idle   = (state_q == S_IDLE) && !rst;
   assign gnt_lk = idle && bus.lkValid && (!bus.upValid || !rr_q);
   assign gnt_up = idle && bus.upValid && (!bus.lkValid || rr_q);
   assign hit    = bus.camMatch && occ_q[bus.camMAddr] && (patt_q != NULLP);
   assign full   = (count_q == (ADDRW+1)'(CAMD));

   always_comb begin
      free_addr = '0;
      for (int i = CAMD-1; i >= 0; i--)
         if (!occ_q[i]) free_addr = ADDRW'(i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_INIT;
         init_addr_q <= '0;
         occ_q       <= '0;
         count_q     <= '0;
         rr_q        <= 1'b0;
         is_lk_q     <= 1'b0;
         op_q        <= 1'b0;
         patt_q      <= '0;
         addr_q      <= '0;
         lat_q       <= '0;
         lk_hit_q    <= 1'b0;
         lk_addr_q   <= '0;
         up_addr_q   <= '0;
         up_dup_q    <= 1'b0;
         up_err_q    <= '0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         occ_q       <= occ_d;
         count_q     <= count_d;
         rr_q        <= rr_d;
         is_lk_q     <= is_lk_d;
         op_q        <= op_d;
         patt_q      <= patt_d;
         addr_q      <= addr_d;
         lat_q       <= lat_d;
         lk_hit_q    <= lk_hit_d;
         lk_addr_q   <= lk_addr_d;
         up_addr_q   <= up_addr_d;
         up_dup_q    <= up_dup_d;
         up_err_q    <= up_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:   if (init_addr_q == ADDRW'(CAMD-1)) state_d = S_IDLE;
         S_IDLE: begin
            if (gnt_lk)
               state_d = S_LOOK;
            else if (gnt_up) begin
               if (bus.upOp) state_d = occ_q[bus.upAddr] ? S_WRITE : S_RESP;
               else          state_d = (bus.upPatt == NULLP) ? S_RESP : S_LOOK;
            end
         end
         S_LOOK:   state_d = (MLAT == 1) ? S_DECIDE : S_WAIT;
         S_WAIT:   if (lat_q == LATW'(1)) state_d = S_DECIDE;
         S_DECIDE: state_d = (!is_lk_q && !hit && !full) ? S_WRITE : S_RESP;
         S_WRITE:  state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_INIT;
      endcase
   end

   always_comb begin
      init_addr_d = init_addr_q;
      occ_d       = occ_q;
      count_d     = count_q;
      rr_d        = rr_q;
      is_lk_d     = is_lk_q;
      op_d        = op_q;
      patt_d      = patt_q;
      addr_d      = addr_q;
      lat_d       = lat_q;
      lk_hit_d    = lk_hit_q;
      lk_addr_d   = lk_addr_q;
      up_addr_d   = up_addr_q;
      up_dup_d    = up_dup_q;
      up_err_d    = up_err_q;
      case (state_q)
         S_INIT: init_addr_d = init_addr_q + 1'b1;
         S_IDLE: begin
            if (gnt_lk || gnt_up) begin
               rr_d    = gnt_lk;
               is_lk_d = gnt_lk;
               op_d    = gnt_up && bus.upOp;
               patt_d  = gnt_lk ? bus.lkPatt : bus.upPatt;
               addr_d  = bus.upAddr;
            end
            // requests rejected without CAM access load their response here
            if (gnt_up && bus.upOp && !occ_q[bus.upAddr]) begin
               up_addr_d = bus.upAddr;
               up_dup_d  = 1'b0;
               up_err_d  = 2'd3;
            end else if (gnt_up && !bus.upOp && bus.upPatt == NULLP) begin
               up_addr_d = '0;
               up_dup_d  = 1'b0;
               up_err_d  = 2'd2;
            end
         end
         S_LOOK: lat_d = LATW'(MLAT-1);
         S_WAIT: lat_d = lat_q - 1'b1;
         S_DECIDE: begin
            if (is_lk_q) begin
               lk_hit_d  = hit;
               lk_addr_d = hit ? bus.camMAddr : '0;
            end else if (hit) begin
               up_addr_d = bus.camMAddr;
               up_dup_d  = 1'b1;
               up_err_d  = 2'd0;
            end else if (full) begin
               up_addr_d = '0;
               up_dup_d  = 1'b0;
               up_err_d  = 2'd1;
            end else begin
               addr_d = free_addr;
            end
         end
         S_WRITE: begin
            occ_d[addr_q] = !op_q;
            count_d       = op_q ? count_q - 1'b1 : count_q + 1'b1;
            up_addr_d     = addr_q;
            up_dup_d      = 1'b0;
            up_err_d      = 2'd0;
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.lkReady   = gnt_lk;
      bus.upReady   = gnt_up;
      bus.busy      = (state_q == S_INIT);
      bus.lkRspVld  = (state_q == S_RESP) && is_lk_q;
      bus.upRspVld  = (state_q == S_RESP) && !is_lk_q;
      bus.lkHit     = lk_hit_q;
      bus.lkAddr    = lk_addr_q;
      bus.upRspAddr = up_addr_q;
      bus.upRspDup  = up_dup_q;
      bus.upRspErr  = up_err_q;
      bus.count     = count_q;
      bus.camWEnb   = ((state_q == S_INIT) && !rst) || (state_q == S_WRITE);
      bus.camWAddr  = (state_q == S_INIT) ? init_addr_q : (state_q == S_WRITE) ? addr_q : '0;
      bus.camWPatt  = ((state_q == S_WRITE) && !op_q) ? patt_q : NULLP;
      bus.camMPatt  = ((state_q == S_LOOK) || (state_q == S_WAIT)) ? patt_q : '0;
   end
endmodule

// File: tb/tb_bcam_ctrl.sv
// tb/tb_bcam_ctrl.sv - scoreboard bench for bcam_ctrl with a behavioural one-cycle CAM
module tb_bcam_ctrl;
   localparam int CAMD = 16;
   localparam int CAMW = 8;

   typedef struct {logic hit; logic [3:0] addr; int due;} lk_exp_t;
   typedef struct {logic [3:0] addr; logic dup; logic [1:0] err; logic chk_addr; int due;} up_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bcam_ctrl_if #(.CAMD(CAMD), .CAMW(CAMW)) bus ();
   bcam_ctrl #(.CAMD(CAMD), .CAMW(CAMW), .MLAT(1), .NULLP(8'hFF)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk = 0, n_pass = 0, cyc = 0, lk_rsp_n = 0, wen_n = 0;
   lk_exp_t lk_q[$];
   up_exp_t up_q[$];
   lk_exp_t le;
   up_exp_t ue;

   logic [7:0] cam_mem [CAMD];
   logic       m_hit;
   logic [3:0] m_addr;

   always_comb begin
      m_hit  = 1'b0;
      m_addr = '0;
      for (int i = CAMD-1; i >= 0; i--)
         if (cam_mem[i] === bus.camMPatt) begin m_hit = 1'b1; m_addr = 4'(i); end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.camWEnb) cam_mem[bus.camWAddr] <= bus.camWPatt;
      bus.camMatch <= m_hit;
      bus.camMAddr <= m_addr;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      if (bus.lkRspVld === 1'b1) begin
         lk_rsp_n++;
         if (lk_q.size() == 0) check("lk_unexpected_rsp", 1, 0);
         else begin
            le = lk_q.pop_front();
            check("lk_hit", bus.lkHit, le.hit);
            check("lk_addr", bus.lkAddr, le.addr);
            check("lk_rsp_cycle", cyc, le.due);
         end
      end
      if (bus.upRspVld === 1'b1) begin
         if (up_q.size() == 0) check("up_unexpected_rsp", 1, 0);
         else begin
            ue = up_q.pop_front();
            if (ue.chk_addr) check("up_addr", bus.upRspAddr, ue.addr);
            check("up_dup", bus.upRspDup, ue.dup);
            check("up_err", bus.upRspErr, ue.err);
            check("up_rsp_cycle", cyc, ue.due);
         end
      end
      if (bus.lkValid && bus.upValid) check("ready_exclusive", bus.lkReady & bus.upReady, 0);
      if (bus.camWEnb && !bus.busy) wen_n++;
   end

   task automatic lookup(input logic [7:0] p, input logic hit, input logic [3:0] a);
      lk_exp_t e;
      bit ok = 0;
      @(posedge clk); #1;
      bus.lkValid = 1'b1; bus.lkPatt = p;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (bus.lkReady) ok = 1;
      end
      if (ok) begin e.hit = hit; e.addr = a; e.due = cyc + 3; lk_q.push_back(e); end
      else check("lk_accept_timeout", 0, 1);
      @(posedge clk); #1;
      bus.lkValid = 1'b0;
   endtask

   task automatic update(input logic op, input logic [7:0] p, input logic [3:0] da,
                         input logic [3:0] ea, input logic dup, input logic [1:0] err,
                         input logic chk_addr, input int lat);
      up_exp_t e;
      bit ok = 0;
      @(posedge clk); #1;
      bus.upValid = 1'b1; bus.upOp = op; bus.upPatt = p; bus.upAddr = da;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (bus.upReady) ok = 1;
      end
      if (ok) begin
         e.addr = ea; e.dup = dup; e.err = err; e.chk_addr = chk_addr; e.due = cyc + lat;
         up_q.push_back(e);
      end else check("up_accept_timeout", 0, 1);
      @(posedge clk); #1;
      bus.upValid = 1'b0;
   endtask

   task automatic drain();
      bit done = 0;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         if (lk_q.size() == 0 && up_q.size() == 0) done = 1;
      end
      if (!done) check("drain_timeout", 0, 1);
      @(negedge clk);
   endtask

   initial begin
      int w, r, nxt, grants;
      bus.lkValid = 0; bus.lkPatt = '0;
      bus.upValid = 0; bus.upOp = 0; bus.upPatt = '0; bus.upAddr = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_outputs", {bus.lkReady, bus.upReady, bus.lkRspVld, bus.upRspVld, bus.lkHit, bus.lkAddr,
                            bus.upRspAddr, bus.upRspDup, bus.upRspErr, bus.count, bus.camWEnb,
                            bus.camWAddr, bus.camMPatt}, 0);
      check("rst_busy", bus.busy, 1);
      check("rst_wpatt", bus.camWPatt, 8'hFF);

      rst = 1'b0; #1;
      for (int i = 0; i < CAMD; i++) begin
         check("init_walk", {bus.busy, bus.camWEnb, bus.camWAddr, bus.camWPatt}, {1'b1, 1'b1, 4'(i), 8'hFF});
         @(negedge clk); #1;
      end
      check("init_done_busy", bus.busy, 0);

      update(0, 8'h3C, 0, 0, 0, 0, 1, 4);
      drain();
      check("count_after_insert", bus.count, 1);
      lookup(8'h3C, 1, 0);
      lookup(8'h55, 0, 0);
      drain();

      w = wen_n;
      update(0, 8'h3C, 0, 0, 1, 0, 1, 3);
      drain();
      check("dup_no_write", wen_n - w, 0);
      update(0, 8'hFF, 0, 0, 0, 2, 1, 1);
      lookup(8'hFF, 0, 0);
      update(1, 8'h00, 0, 0, 0, 0, 1, 2);
      drain();
      check("count_after_delete", bus.count, 0);
      lookup(8'h3C, 0, 0);
      update(1, 8'h00, 0, 0, 0, 3, 0, 1);
      drain();

      for (int i = 0; i < CAMD; i++) update(0, 8'h10 + 8'(i), 0, 4'(i), 0, 0, 1, 4);
      drain();
      check("count_full", bus.count, 16);
      update(0, 8'h20, 0, 0, 0, 1, 1, 3);
      lookup(8'h1A, 1, 10);
      update(1, 8'h00, 5, 5, 0, 0, 1, 2);
      update(0, 8'h77, 0, 5, 0, 0, 1, 4);
      lookup(8'h77, 1, 5);
      lookup(8'h15, 0, 0);
      drain();
      check("count_reuse", bus.count, 16);

      r = lk_rsp_n;
      @(posedge clk); #1;
      bus.lkValid = 1'b1; bus.lkPatt = 8'h1A;
      begin
         bit ok = 0;
         for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (bus.lkReady) ok = 1;
         end
         check("rst_lk_accept", ok, 1);
      end
      @(posedge clk); #1;
      bus.lkValid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; #1;
      check("rst_restart_init", {bus.busy, bus.camWEnb, bus.camWAddr, bus.count}, {1'b1, 1'b1, 4'd0, 5'd0});
      repeat (20) @(negedge clk);
      check("rst_no_lk_rsp", lk_rsp_n - r, 0);
      check("rst_init_done", bus.busy, 0);

      @(posedge clk); #1;
      bus.lkValid = 1'b1; bus.lkPatt = 8'h3C;
      bus.upValid = 1'b1; bus.upOp = 1'b1; bus.upAddr = 4'd3;
      nxt = 0; grants = 0;
      for (int k = 0; k < 60 && grants < 6; k++) begin
         @(negedge clk);
         if (bus.lkReady || bus.upReady) begin
            check("arb_order", bus.lkReady ? 0 : 1, nxt);
            if (bus.lkReady) begin
               le.hit = 0; le.addr = 0; le.due = cyc + 3; lk_q.push_back(le);
            end else begin
               ue.addr = 3; ue.dup = 0; ue.err = 3; ue.chk_addr = 0; ue.due = cyc + 1; up_q.push_back(ue);
            end
            nxt = 1 - nxt;
            grants++;
         end
      end
      @(posedge clk); #1;
      bus.lkValid = 1'b0; bus.upValid = 1'b0;
      check("arb_grants", grants, 6);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
